// File: rtl/fetch_prefetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_prefetch_unit
//
// Instruction-fetch stage. Issues sequential word fetches to the instruction
// memory and buffers the returned words in a small in-order prefetch queue
// that feeds the decode register. A redirect (branch/jump/trap) flushes the
// queue, restarts fetch at the new address and discards every response still
// owed by the memory for the old stream.
//
// Parameters
//   RESET_PC    fetch address after reset
//   DEPTH       prefetch queue entries, also the maximum requests in flight
//   NOP_INSTR   value presented on inst when no instruction is valid
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   imem_req     fetch request valid
//   imem_addr    fetch byte address (word aligned), stable while req && !gnt
//   imem_gnt     memory accepts the request this cycle
//   imem_rvalid  read data valid, responses return in issue order
//   imem_rdata   instruction word
//   redirect     restart fetch at redirect_pc (overrides stall)
//   redirect_pc  new fetch address, bits [1:0] ignored
//   stall        decode cannot accept, head entry is held
//   inst_valid   head entry valid, consumed when inst_valid && !stall
//   inst         head instruction (NOP_INSTR when not valid)
//   inst_pc      PC of head instruction (0 when not valid)
//   misalign     one-cycle pulse after a redirect to a non-word-aligned PC
// ---------------------------------------------------------------------------
module fetch_prefetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        misalign
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = CW + 2;

    logic [31:0]   fetch_pc;
    logic [CW-1:0] count;
    logic [CW-1:0] inflight;
    logic [CW-1:0] discard;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   pc_q   [DEPTH];

    logic [SW-1:0] credits_used;
    logic [SW-1:0] stale_left;
    logic [31:0]   resp_pc;
    logic          issue;
    logic          resp_drop;
    logic          resp_live;
    logic          push;
    logic          pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Every queue slot is reserved at issue time: an entry that is buffered,
    // still owed by memory, or owed but to be thrown away all hold a credit.
    // That is what lets a live response always find a free slot.
    assign credits_used = SW'(count) + SW'(inflight) + SW'(discard);
    assign imem_req     = !reset && !redirect && (credits_used < SW'(DEPTH));
    assign imem_addr    = fetch_pc;
    assign issue        = imem_req && imem_gnt;

    // Stale responses are always older than live ones, so they are retired
    // first. A response with nothing outstanding is ignored.
    assign resp_drop = imem_rvalid && (discard != '0);
    assign resp_live = imem_rvalid && (discard == '0) && (inflight != '0);
    assign push      = resp_live && !redirect;
    assign pop       = inst_valid && !stall;

    // Live requests after a redirect are strictly sequential, so the oldest
    // outstanding one was issued inflight words before the current fetch_pc.
    assign resp_pc = fetch_pc - (32'(inflight) << 2);

    assign inst_valid = (count != '0);
    assign inst       = inst_valid ? data_q[head] : NOP_INSTR;
    assign inst_pc    = inst_valid ? pc_q[head]   : 32'h0;

    // On a redirect every old-stream request becomes a discard, minus the one
    // whose response (if any) arrives in the redirect cycle itself.
    always_comb begin
        stale_left = SW'(discard) + SW'(inflight);
        if (imem_rvalid && (stale_left != '0)) begin
            stale_left = stale_left - SW'(1);
        end
    end

    // Control state: fetch address, queue occupancy and the credit counters.
    // Redirect wins over everything else, including stall and responses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            count    <= '0;
            inflight <= '0;
            discard  <= '0;
            head     <= '0;
            tail     <= '0;
            misalign <= 1'b0;
        end else if (redirect) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            count    <= '0;
            inflight <= '0;
            discard  <= CW'(stale_left);
            head     <= '0;
            tail     <= '0;
            misalign <= (redirect_pc[1:0] != 2'b00);
        end else begin
            misalign <= 1'b0;
            if (issue) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (resp_drop) begin
                discard <= discard - CW'(1);
            end
            case ({issue, resp_live})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push) begin
                tail <= next_ptr(tail);
            end
            if (pop) begin
                head <= next_ptr(head);
            end
        end
    end

    // Queue storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[tail] <= imem_rdata;
            pc_q[tail]   <= resp_pc;
        end
    end

    // The memory must never answer a request that was not issued.
    rvalid_has_owner: assert property (@(posedge clk) disable iff (reset)
        imem_rvalid |-> ((inflight != '0) || (discard != '0)));

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_prefetch_unit
//
// Directed bench for fetch_prefetch_unit (RESET_PC=0, DEPTH=2). A small
// in-order memory model answers each issued request after a programmable
// latency with rdata equal to the request address. A scoreboard queue is
// loaded with the expected PC stream whenever fetch is (re)started and is
// popped on every instruction the decode side accepts. Directed checks pin
// down cycle-exact behaviour of the individual scenarios.
// ---------------------------------------------------------------------------
module tb_fetch_prefetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        misalign;

    int          errors;
    int          checks;
    int          lat;
    logic        pv [4];
    logic [31:0] pa [4];
    logic [31:0] exp_q [$];
    logic [31:0] exp_pc;

    fetch_prefetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .DEPTH     (2),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .misalign    (misalign)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Fetch (re)starts at pc: whatever decode accepts from now on must be
    // pc, pc+4, pc+8, ... with the instruction word equal to its address.
    task automatic startStream(input logic [31:0] pc);
        exp_q.delete();
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back(pc + 32'(4 * i));
        end
    endtask

    task automatic clearMemory();
        for (int i = 0; i < 4; i++) begin
            pv[i] = 1'b0;
            pa[i] = 32'h0;
        end
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
    endtask

    // Finish the current cycle (scoreboard compare and issue capture at the
    // falling edge), advance the memory model past the next rising edge and
    // drive the inputs for the new cycle.
    task automatic applyStimulus(input logic st, input logic gn,
                                 input logic rd, input logic [31:0] rpc);
        logic        issued;
        logic [31:0] issued_addr;
        @(negedge clk);
        if (!reset && inst_valid && !stall && !redirect) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("[TB] FAIL sb_extra: observed=%h expected=none", inst_pc);
            end
            if (exp_q.size() != 0) begin
                exp_pc = exp_q.pop_front();
                checkOutput("sb_inst_pc", inst_pc, exp_pc);
                checkOutput("sb_inst", inst, exp_pc);
            end
        end
        issued      = !reset && imem_req && imem_gnt;
        issued_addr = imem_addr;
        @(posedge clk);
        #1;
        if (reset) begin
            clearMemory();
        end else begin
            if (issued) begin
                pv[lat-1] = 1'b1;
                pa[lat-1] = issued_addr;
            end
            imem_rvalid = pv[0];
            imem_rdata  = pv[0] ? pa[0] : 32'hDEAD_BEEF;
            for (int i = 0; i < 3; i++) begin
                pv[i] = pv[i+1];
                pa[i] = pa[i+1];
            end
            pv[3] = 1'b0;
        end
        stall       = st;
        imem_gnt    = gn;
        redirect    = rd;
        redirect_pc = rpc;
        if (rd) begin
            startStream({rpc[31:2], 2'b00});
        end
    endtask

    // Let the combinational outputs settle, well clear of either edge.
    task automatic peek();
        #2;
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        lat         = 1;
        reset       = 1'b1;
        imem_gnt    = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        stall       = 1'b0;
        clearMemory();

        // Reset values
        @(posedge clk);
        #1;
        peek();
        checkOutput("rst_req", 32'(imem_req), 0);
        checkOutput("rst_valid", 32'(inst_valid), 0);
        checkOutput("rst_inst", inst, 32'h13);
        checkOutput("rst_inst_pc", inst_pc, 0);
        checkOutput("rst_misalign", 32'(misalign), 0);

        // Stream from reset, one-cycle memory. With two credits the unit
        // delivers two of every three cycles.
        applyStimulus(0, 1, 0, 0);
        reset = 1'b0;
        startStream(32'h0);
        peek();
        checkOutput("c0_req", 32'(imem_req), 1);
        checkOutput("c0_addr", imem_addr, 32'h0);
        checkOutput("c0_valid", 32'(inst_valid), 0);
        applyStimulus(0, 1, 0, 0); peek();
        checkOutput("c1_addr", imem_addr, 32'h4);
        checkOutput("c1_valid", 32'(inst_valid), 0);
        applyStimulus(0, 1, 0, 0); peek();
        checkOutput("c2_valid", 32'(inst_valid), 1);
        checkOutput("c2_inst_pc", inst_pc, 32'h0);
        checkOutput("c2_inst", inst, 32'h0);
        checkOutput("c2_req", 32'(imem_req), 0);
        applyStimulus(0, 1, 0, 0); peek();
        checkOutput("c3_inst_pc", inst_pc, 32'h4);
        applyStimulus(0, 1, 0, 0); peek();
        checkOutput("c4_valid", 32'(inst_valid), 0);
        checkOutput("c4_addr", imem_addr, 32'hC);
        applyStimulus(0, 1, 0, 0); peek();
        checkOutput("c5_inst_pc", inst_pc, 32'h8);

        // Six stall cycles: credits run out, head is held
        applyStimulus(1, 1, 0, 0); peek();
        checkOutput("c6_inst_pc", inst_pc, 32'hC);
        checkOutput("c6_req", 32'(imem_req), 1);
        applyStimulus(1, 1, 0, 0); peek();
        checkOutput("c7_req", 32'(imem_req), 0);
        applyStimulus(1, 1, 0, 0); peek();
        checkOutput("c8_inst_pc", inst_pc, 32'hC);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 0, 0);
        end
        peek();
        checkOutput("c11_req", 32'(imem_req), 0);
        checkOutput("c11_valid", 32'(inst_valid), 1);
        checkOutput("c11_inst_pc", inst_pc, 32'hC);
        applyStimulus(0, 1, 0, 0); peek();
        checkOutput("c12_inst_pc", inst_pc, 32'hC);
        applyStimulus(0, 1, 0, 0); peek();
        checkOutput("c13_inst_pc", inst_pc, 32'h10);
        checkOutput("c13_addr", imem_addr, 32'h14);
        applyStimulus(0, 1, 0, 0); peek();
        checkOutput("c14_valid", 32'(inst_valid), 0);
        checkOutput("c14_addr", imem_addr, 32'h18);
        applyStimulus(0, 1, 0, 0); peek();
        checkOutput("c15_inst_pc", inst_pc, 32'h14);

        // Grant withheld for three cycles while the request is up
        applyStimulus(0, 0, 0, 0); peek();
        checkOutput("c16_req", 32'(imem_req), 1);
        checkOutput("c16_addr", imem_addr, 32'h1C);
        applyStimulus(0, 0, 0, 0); peek();
        checkOutput("c17_addr", imem_addr, 32'h1C);
        applyStimulus(0, 0, 0, 0); peek();
        checkOutput("c18_addr", imem_addr, 32'h1C);
        checkOutput("c18_req", 32'(imem_req), 1);
        applyStimulus(0, 1, 0, 0); peek();
        checkOutput("c19_addr", imem_addr, 32'h1C);
        applyStimulus(0, 1, 0, 0); peek();
        checkOutput("c20_addr", imem_addr, 32'h20);
        checkOutput("c20_valid", 32'(inst_valid), 0);
        applyStimulus(0, 0, 0, 0); peek();
        checkOutput("c21_inst_pc", inst_pc, 32'h1C);
        applyStimulus(0, 0, 0, 0);

        // Two-cycle memory, redirect to 0x100 with two requests in flight
        lat = 2;
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 1, 32'h100); peek();
        checkOutput("c25_req", 32'(imem_req), 0);
        applyStimulus(0, 1, 0, 0); peek();
        checkOutput("c26_addr", imem_addr, 32'h100);
        checkOutput("c26_req", 32'(imem_req), 1);
        checkOutput("c26_valid", 32'(inst_valid), 0);
        applyStimulus(0, 1, 0, 0); peek();
        checkOutput("c27_valid", 32'(inst_valid), 0);
        applyStimulus(0, 1, 0, 0); peek();
        checkOutput("c28_valid", 32'(inst_valid), 0);
        applyStimulus(0, 1, 0, 0); peek();
        checkOutput("c29_inst_pc", inst_pc, 32'h100);

        // Misaligned redirect while decode is stalled
        applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 1, 1, 32'h102); peek();
        checkOutput("c33_inst_pc", inst_pc, 32'h104);
        applyStimulus(1, 1, 0, 0); peek();
        checkOutput("c34_misalign", 32'(misalign), 1);
        checkOutput("c34_valid", 32'(inst_valid), 0);
        checkOutput("c34_addr", imem_addr, 32'h100);
        applyStimulus(0, 1, 0, 0); peek();
        checkOutput("c35_misalign", 32'(misalign), 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0); peek();
        checkOutput("c37_inst_pc", inst_pc, 32'h100);

        // Redirect to the last word of the address space, fetch wraps to 0
        applyStimulus(0, 1, 1, 32'hFFFF_FFFC); peek();
        checkOutput("c38_req", 32'(imem_req), 0);
        applyStimulus(0, 1, 0, 0); peek();
        checkOutput("c39_misalign", 32'(misalign), 0);
        checkOutput("c39_addr", imem_addr, 32'hFFFF_FFFC);
        applyStimulus(0, 1, 0, 0); peek();
        checkOutput("c40_addr", imem_addr, 32'h0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0); peek();
        checkOutput("c42_inst_pc", inst_pc, 32'hFFFF_FFFC);
        applyStimulus(0, 1, 0, 0); peek();
        checkOutput("c43_inst_pc", inst_pc, 32'h0);

        // Asynchronous reset in the middle of a cycle
        applyStimulus(0, 1, 0, 0);
        #2;
        reset = 1'b1;
        clearMemory();
        #1;
        checkOutput("arst_req", 32'(imem_req), 0);
        checkOutput("arst_valid", 32'(inst_valid), 0);
        checkOutput("arst_inst", inst, 32'h13);
        checkOutput("arst_inst_pc", inst_pc, 0);
        checkOutput("arst_misalign", 32'(misalign), 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        reset = 1'b0;
        startStream(32'h0);
        peek();
        checkOutput("r0_addr", imem_addr, 32'h0);
        checkOutput("r0_req", 32'(imem_req), 1);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0); peek();
        checkOutput("r2_valid", 32'(inst_valid), 0);
        applyStimulus(0, 1, 0, 0); peek();
        checkOutput("r3_inst_pc", inst_pc, 32'h0);
        checkOutput("r3_inst", inst, 32'h0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
